// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte RAM owner serving a fetch port and a serialized data load/store port
// Optional MEM_CTRL_STAT_EN adds fetch-cycle and data-transaction counters.
module mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [7:0]        if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_width_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
`ifdef MEM_CTRL_STAT_EN
  ,
  output logic [31:0]       stat_if_o,
  output logic [31:0]       stat_mem_o
`endif
);

  if (RAM_LAT != 1) begin : g_lat_check
    $error("mem_ctrl supports only RAM_LAT == 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_RD  = 3'd1,
    D_WR  = 3'd2,
    D_FIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        last_q;
  logic [1:0]        k_q;
  logic [23:0]       buf_q;
  logic [31:0]       rdata_q;
  logic              accept;
  logic              last_byte;
  logic [1:0]        last_idx;

  assign accept    = (state == IDLE) && mem_req_i;
  assign last_byte = (k_q == last_q);

  always_comb begin
    last_idx = 2'd3;
    case (mem_width_i)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_req_i) state_nxt = mem_we_i ? D_WR : D_RD;
      D_RD:    if (last_byte) state_nxt = D_FIN;
      D_WR:    if (last_byte) state_nxt = DONE;
      D_FIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte k arrives one cycle after its address, so D_RD at k stores byte k-1
  // and D_FIN stores the final byte while publishing the assembled word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= '0;
      k_q     <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= mem_addr_i;
        wdata_q <= mem_wdata_i;
        last_q  <= last_idx;
        k_q     <= '0;
        buf_q   <= '0;
      end else if (state == D_RD || state == D_WR) begin
        k_q <= k_q + 2'd1;
      end
      if (state == D_RD) begin
        case (k_q)
          2'd1:    buf_q[7:0]   <= ram_din_i;
          2'd2:    buf_q[15:8]  <= ram_din_i;
          2'd3:    buf_q[23:16] <= ram_din_i;
          default: ;
        endcase
      end
      if (state == D_FIN) begin
        case (last_q)
          2'd0:    rdata_q <= {24'h0, ram_din_i};
          2'd1:    rdata_q <= {16'h0, ram_din_i, buf_q[7:0]};
          default: rdata_q <= {ram_din_i, buf_q};
        endcase
      end
    end
  end

  always_comb begin
    ram_addr_o  = if_addr_i;
    ram_dout_o  = 8'h00;
    ram_wr_o    = 1'b0;
    mem_done_o  = (state == DONE);
    stall_req_o = mem_req_i || (state != IDLE);
    if_data_o   = ram_din_i;
    mem_rdata_o = rdata_q;
    if (state == D_RD || state == D_WR) begin
      ram_addr_o = addr_q + ADDR_W'(k_q);
    end
    if (state == D_WR) begin
      ram_wr_o   = 1'b1;
      ram_dout_o = wdata_q[8*k_q +: 8];
    end
  end

`ifdef MEM_CTRL_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_o  <= '0;
      stat_mem_o <= '0;
    end else begin
      if (state == IDLE && if_req_i) stat_if_o <= stat_if_o + 32'd1;
      if (accept)                    stat_mem_o <= stat_mem_o + 32'd1;
    end
  end
`else
  logic unused_if_req;
  assign unused_if_req = if_req_i;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl with a 1-cycle byte RAM model
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [7:0]  if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall_req;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  logic [7:0]  ram [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [7:0]  pre_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .RAM_LAT(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_data_o   (if_data),
    .mem_req_i   (mem_req),
    .mem_we_i    (mem_we),
    .mem_width_i (mem_width),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_rdata_o (mem_rdata),
    .mem_done_o  (mem_done),
    .stall_req_o (stall_req),
    .ram_addr_o  (ram_addr),
    .ram_dout_o  (ram_dout),
    .ram_wr_o    (ram_wr),
    .ram_din_i   (ram_din)
  );

  // RAM model: 1 KiB aliased over the address space, read latency one cycle.
  always @(posedge clk) begin
    if (pre_we)      ram[pre_addr] <= pre_data;
    else if (ram_wr) ram[ram_addr[9:0]] <= ram_dout;
    ram_din <= ram[ram_addr[9:0]];
  end

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      'h000: return 8'h22;
      'h001: return 8'h33;
      'h002: return 8'h44;
      'h003: return 8'h55;
      'h100: return 8'h13;
      'h103: return 8'h93;
      'h201: return 8'h5A;
      'h3FF: return 8'h11;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] fexp [0:3];
    fexp[0] = 8'h22; fexp[1] = 8'h33; fexp[2] = 8'h44; fexp[3] = 8'h55;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_width = 2'b00; mem_addr = '0; mem_wdata = '0;
    pre_we = 1'b1; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 1024; i++) begin
      pre_addr = 10'(i);
      pre_data = init_byte(i);
      tick();
    end
    pre_we = 1'b0;
    #1;
    chk("rst_done", mem_done, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_wr", ram_wr, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_dout", ram_dout, 0);
    rst_n = 1'b1;
    tick();

    // fetch pass-through
    if_req = 1'b1;
    for (int a = 0; a < 4; a++) begin
      if_addr = 32'(a);
      #1;
      chk("fetch_stall", stall_req, 0);
      chk("fetch_addr", ram_addr, 32'(a));
      tick();
      chk("fetch_data", if_data, fexp[a]);
    end
    if_req = 1'b0;

    // word load at 0x100
    mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b10; mem_addr = 32'h100;
    #1;
    chk("ldw_stall_T", stall_req, 1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("ldw_done_early", mem_done, 0);
      chk("ldw_stall", stall_req, 1);
      if (c <= 4) chk("ldw_addr", ram_addr, 32'h100 + 32'(c - 1));
    end
    tick();
    chk("ldw_done", mem_done, 1);
    chk("ldw_rdata", mem_rdata, 32'h93000013);
    chk("ldw_stall_done", stall_req, 1);
    mem_req = 1'b0;
    tick();
    chk("ldw_idle_done", mem_done, 0);
    chk("ldw_idle_stall", stall_req, 0);

    // byte store at 0x200
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b00; mem_addr = 32'h200; mem_wdata = 32'hAABBCCDD;
    tick();
    chk("stb_wr", ram_wr, 1);
    chk("stb_addr", ram_addr, 32'h200);
    chk("stb_dout", ram_dout, 8'hDD);
    chk("stb_done_early", mem_done, 0);
    tick();
    chk("stb_done", mem_done, 1);
    chk("stb_wr_off", ram_wr, 0);
    mem_req = 1'b0;
    chk("stb_ram200", ram['h200], 8'hDD);
    chk("stb_ram201", ram['h201], 8'h5A);
    chk("stb_rdata_hold", mem_rdata, 32'h93000013);
    tick();

    // half load wrapping past the top of the address space
    mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b01; mem_addr = 32'hFFFFFFFF;
    tick();
    chk("ldh_addr0", ram_addr, 32'hFFFFFFFF);
    tick();
    chk("ldh_addr1", ram_addr, 32'h0);
    tick();
    chk("ldh_done_early", mem_done, 0);
    tick();
    chk("ldh_done", mem_done, 1);
    chk("ldh_rdata", mem_rdata, 32'h00002211);
    mem_req = 1'b0;
    tick();

    // fetch interrupted by a byte load; fetch re-issues afterwards
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("int_fetch0", if_data, 8'h13);
    if_addr = 32'h101;
    mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b00; mem_addr = 32'h103;
    #1;
    chk("int_stall_T", stall_req, 1);
    tick();
    chk("int_addr", ram_addr, 32'h103);
    chk("int_stall1", stall_req, 1);
    tick();
    chk("int_stall2", stall_req, 1);
    tick();
    chk("int_done", mem_done, 1);
    chk("int_rdata", mem_rdata, 32'h00000093);
    mem_req = 1'b0;
    for (int a = 1; a < 4; a++) begin
      if_addr = 32'h100 + 32'(a);
      tick();
      chk("int_fetch_stall", stall_req, 0);
      chk("int_fetch", if_data, (a == 3) ? 8'h93 : 8'h00);
    end
    if_req = 1'b0; if_addr = 32'h3;

    // reset during the third byte of a word store
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b10; mem_addr = 32'h300; mem_wdata = 32'h44332211;
    tick();
    chk("rs_dout0", ram_dout, 8'h11);
    tick();
    tick();
    chk("rs_wr2", ram_wr, 1);
    chk("rs_addr2", ram_addr, 32'h302);
    chk("rs_dout2", ram_dout, 8'h33);
    rst_n = 1'b0; mem_req = 1'b0;
    #1;
    chk("rs_wr_drop", ram_wr, 0);
    chk("rs_done", mem_done, 0);
    chk("rs_idle_addr", ram_addr, 32'h3);
    chk("rs_rdata", mem_rdata, 0);
    tick();
    chk("rs_ram300", ram['h300], 8'h11);
    chk("rs_ram301", ram['h301], 8'h22);
    chk("rs_ram302", ram['h302], 8'h00);
    chk("rs_ram303", ram['h303], 8'h00);
    rst_n = 1'b1;
    tick();
    chk("rs_after_done", mem_done, 0);
    chk("rs_after_stall", stall_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
